// File: rtl/ph_reg3_sync_if.sv
// Bus bundle for the register-3 parasite-to-host FIFO.
// The error-flag signals exist only when PH_REG3_ERROR_FLAGS_EN is defined.
interface ph_reg3_sync_if #(
    parameter int DATA_W = 8
);
    logic              one_byte_mode;
    logic              p_selectData;
    logic              p_we;
    logic [DATA_W-1:0] p_data;
    logic              h_selectData;
    logic              h_rdnw;
    logic [DATA_W-1:0] h_data;
    logic              h_data_available;
    logic              h_two_bytes_available;
    logic              p_full;

`ifdef PH_REG3_ERROR_FLAGS_EN
    logic err_clr;
    logic p_overrun;
    logic h_underrun;

    modport master (
        output one_byte_mode, p_selectData, p_we, p_data, h_selectData, h_rdnw, err_clr,
        input  h_data, h_data_available, h_two_bytes_available, p_full, p_overrun, h_underrun
    );

    modport slave (
        input  one_byte_mode, p_selectData, p_we, p_data, h_selectData, h_rdnw, err_clr,
        output h_data, h_data_available, h_two_bytes_available, p_full, p_overrun, h_underrun
    );
`else
    modport master (
        output one_byte_mode, p_selectData, p_we, p_data, h_selectData, h_rdnw,
        input  h_data, h_data_available, h_two_bytes_available, p_full
    );

    modport slave (
        input  one_byte_mode, p_selectData, p_we, p_data, h_selectData, h_rdnw,
        output h_data, h_data_available, h_two_bytes_available, p_full
    );
`endif
endinterface

// File: rtl/ph_reg3_sync.sv
// Two-byte parasite-to-host FIFO for register 3, single clock, updates on falling h_phi2.
// Define PH_REG3_ERROR_FLAGS_EN to add sticky overrun/underrun flags with err_clr.
module ph_reg3_sync #(
    parameter int DATA_W = 8
) (
    input logic           h_phi2,
    input logic           h_rst_b,
    ph_reg3_sync_if.slave bus
);

    typedef enum logic [2:0] {
        EMPTY,
        FILL1,
        FULL2,
        DRAIN1,
        ONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_byte0;
    logic [DATA_W-1:0] r_byte1;
    logic              r_mode;

    logic w_wr;
    logic w_rd;
    logic w_flush;

    assign w_wr    = bus.p_selectData & bus.p_we;
    assign w_rd    = bus.h_selectData & bus.h_rdnw;
    assign w_flush = r_mode != bus.one_byte_mode;

    // A mode change flushes to EMPTY and overrides any access on that edge.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r_state <= EMPTY;
            r_byte0 <= '0;
            r_byte1 <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_mode <= bus.one_byte_mode;
            if (w_flush) begin
                r_state <= EMPTY;
            end else if (r_mode) begin
                case (r_state)
                    EMPTY: begin
                        if (w_wr) begin
                            r_byte0 <= bus.p_data;
                            r_state <= ONE;
                        end
                    end
                    ONE: begin
                        if (w_wr) begin
                            r_byte0 <= bus.p_data;
                        end else if (w_rd) begin
                            r_state <= EMPTY;
                        end
                    end
                    default: r_state <= EMPTY;
                endcase
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_wr) begin
                            r_byte0 <= bus.p_data;
                            r_state <= FILL1;
                        end
                    end
                    FILL1: begin
                        if (w_wr) begin
                            r_byte1 <= bus.p_data;
                            r_state <= FULL2;
                        end
                    end
                    FULL2: begin
                        if (w_rd) r_state <= DRAIN1;
                    end
                    DRAIN1: begin
                        if (w_rd) r_state <= EMPTY;
                    end
                    default: r_state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.h_data                = (r_state == DRAIN1) ? r_byte1 : r_byte0;
    assign bus.h_data_available      = (r_state == FULL2) || (r_state == DRAIN1) || (r_state == ONE);
    assign bus.p_full                = (r_state == FULL2) || (r_state == DRAIN1) || (r_state == ONE);
    assign bus.h_two_bytes_available = (r_state == FULL2) && !bus.one_byte_mode;

`ifdef PH_REG3_ERROR_FLAGS_EN
    logic w_ovr_set;
    logic w_und_set;
    logic r_p_overrun;
    logic r_h_underrun;

    assign w_ovr_set = w_wr && !w_flush && !r_mode && ((r_state == FULL2) || (r_state == DRAIN1));
    assign w_und_set = w_rd && !w_flush && ((r_state == EMPTY) || (r_state == FILL1));

    // A set on the same edge as err_clr takes priority.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            r_p_overrun  <= 1'b0;
            r_h_underrun <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_p_overrun <= 1'b1;
            end else if (bus.err_clr) begin
                r_p_overrun <= 1'b0;
            end
            if (w_und_set) begin
                r_h_underrun <= 1'b1;
            end else if (bus.err_clr) begin
                r_h_underrun <= 1'b0;
            end
        end
    end

    assign bus.p_overrun  = r_p_overrun;
    assign bus.h_underrun = r_h_underrun;
`endif

endmodule

// File: tb/tb_ph_reg3_sync.sv
// Scoreboard bench for ph_reg3_sync: directed accesses push expected outputs, a monitor pops and compares.
// Error-flag expectations are compared only when PH_REG3_ERROR_FLAGS_EN is defined.
module tb_ph_reg3_sync;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       avail;
        logic       two;
        logic       full;
        logic       ovr;
        logic       und;
    } exp_t;

    logic h_phi2 = 1'b0;
    logic h_rst_b;
    int   nChecks = 0;
    int   nErrors = 0;
    exp_t sb[$];
    event sampleNow;

    ph_reg3_sync_if #(.DATA_W(8)) bus ();

    ph_reg3_sync #(.DATA_W(8)) dut (
        .h_phi2 (h_phi2),
        .h_rst_b(h_rst_b),
        .bus    (bus)
    );

    always #5 h_phi2 = ~h_phi2;

    // One access cycle: drive after the rising edge, release just after the falling edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd,
                                 input logic mode, input logic clr);
        @(posedge h_phi2);
        #1;
        bus.one_byte_mode = mode;
        bus.p_selectData  = wr;
        bus.p_we          = wr;
        bus.p_data        = d;
        bus.h_selectData  = rd;
        bus.h_rdnw        = rd;
`ifdef PH_REG3_ERROR_FLAGS_EN
        bus.err_clr       = clr;
`else
        if (clr) $display("[TB] note: err_clr ignored in this build");
`endif
        @(negedge h_phi2);
        #1;
        bus.p_selectData = 1'b0;
        bus.p_we         = 1'b0;
        bus.h_selectData = 1'b0;
        bus.h_rdnw       = 1'b0;
`ifdef PH_REG3_ERROR_FLAGS_EN
        bus.err_clr      = 1'b0;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [7:0] data, input logic avail,
                               input logic two, input logic full, input logic ovr, input logic und);
        exp_t e;
        e.name  = name;
        e.data  = data;
        e.avail = avail;
        e.two   = two;
        e.full  = full;
        e.ovr   = ovr;
        e.und   = und;
        sb.push_back(e);
    endtask

    // Monitor: compares on every rising edge (mid-cycle) or when explicitly poked.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge h_phi2 or sampleNow);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = (bus.h_data !== e.data) || (bus.h_data_available !== e.avail) ||
                      (bus.h_two_bytes_available !== e.two) || (bus.p_full !== e.full);
`ifdef PH_REG3_ERROR_FLAGS_EN
                bad = bad || (bus.p_overrun !== e.ovr) || (bus.h_underrun !== e.und);
                if (bad)
                    $display("[TB] FAIL %s: got data=%h avail=%b two=%b full=%b ovr=%b und=%b, need data=%h avail=%b two=%b full=%b ovr=%b und=%b",
                             e.name, bus.h_data, bus.h_data_available, bus.h_two_bytes_available,
                             bus.p_full, bus.p_overrun, bus.h_underrun,
                             e.data, e.avail, e.two, e.full, e.ovr, e.und);
`else
                if (bad)
                    $display("[TB] FAIL %s: got data=%h avail=%b two=%b full=%b, need data=%h avail=%b two=%b full=%b",
                             e.name, bus.h_data, bus.h_data_available, bus.h_two_bytes_available,
                             bus.p_full, e.data, e.avail, e.two, e.full);
`endif
                nChecks++;
                if (bad) nErrors++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.one_byte_mode = 1'b0;
        bus.p_selectData  = 1'b0;
        bus.p_we          = 1'b0;
        bus.p_data        = 8'h00;
        bus.h_selectData  = 1'b0;
        bus.h_rdnw        = 1'b0;
`ifdef PH_REG3_ERROR_FLAGS_EN
        bus.err_clr       = 1'b0;
`endif
        h_rst_b = 1'b1;
        #1 h_rst_b = 1'b0;
        #1;
        checkOutput("reset", 8'h00, 0, 0, 0, 0, 0);
        -> sampleNow;
        @(posedge h_phi2);
        #1 h_rst_b = 1'b1;

        // Two-byte fill and drain
        applyStimulus(1, 8'h12, 0, 0, 0); checkOutput("fill1_12", 8'h12, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h34, 0, 0, 0); checkOutput("full2_34", 8'h12, 1, 1, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("drain1",   8'h34, 1, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("empty",    8'h12, 0, 0, 0, 0, 0);

        // Underrun and clear
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("underrun", 8'h12, 0, 0, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1); checkOutput("errclr",   8'h12, 0, 0, 0, 0, 0);

        // Overrun while full: 0x99 is lost
        applyStimulus(1, 8'h12, 0, 0, 0); checkOutput("refill1",  8'h12, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h34, 0, 0, 0); checkOutput("refull2",  8'h12, 1, 1, 1, 0, 0);
        applyStimulus(1, 8'h99, 0, 0, 0); checkOutput("overrun",  8'h12, 1, 1, 1, 1, 0);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("ovr_rd1",  8'h34, 1, 0, 1, 1, 0);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("ovr_rd2",  8'h12, 0, 0, 0, 1, 0);

        // Same-edge read+write in FILL1: write wins, read counted as underrun
        applyStimulus(1, 8'h56, 0, 0, 0); checkOutput("sim_fill1", 8'h56, 0, 0, 0, 1, 0);
        applyStimulus(1, 8'h78, 1, 0, 0); checkOutput("sim_full2", 8'h56, 1, 1, 1, 1, 1);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("sim_rd1",   8'h78, 1, 0, 1, 1, 1);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("sim_rd2",   8'h56, 0, 0, 0, 1, 1);

        // One-byte mode latch
        applyStimulus(0, 8'h00, 0, 1, 0); checkOutput("mode1_flush", 8'h56, 0, 0, 0, 1, 1);
        applyStimulus(1, 8'hA5, 0, 1, 0); checkOutput("one_a5",      8'hA5, 1, 0, 1, 1, 1);
        applyStimulus(1, 8'h5A, 1, 1, 0); checkOutput("one_rw_5a",   8'h5A, 1, 0, 1, 1, 1);
        applyStimulus(0, 8'h00, 1, 1, 0); checkOutput("one_read",    8'h5A, 0, 0, 0, 1, 1);

        // Mode toggle flushes FILL1, overriding a same-edge write
        applyStimulus(0, 8'h00, 0, 0, 0); checkOutput("mode0_flush", 8'h5A, 0, 0, 0, 1, 1);
        applyStimulus(1, 8'h77, 0, 0, 0); checkOutput("fill1_77",    8'h77, 0, 0, 0, 1, 1);
        applyStimulus(1, 8'h88, 0, 1, 0); checkOutput("toggle_flush", 8'h77, 0, 0, 0, 1, 1);
        applyStimulus(0, 8'h00, 0, 0, 0); checkOutput("toggle_back", 8'h77, 0, 0, 0, 1, 1);

        // Async reset in DRAIN1
        applyStimulus(1, 8'h11, 0, 0, 0); checkOutput("pre_fill1",  8'h11, 0, 0, 0, 1, 1);
        applyStimulus(1, 8'h22, 0, 0, 0); checkOutput("pre_full2",  8'h11, 1, 1, 1, 1, 1);
        applyStimulus(0, 8'h00, 1, 0, 0); checkOutput("pre_drain1", 8'h22, 1, 0, 1, 1, 1);
        @(posedge h_phi2);
        #1 h_rst_b = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 0, 0, 0, 0, 0);
        -> sampleNow;
        @(posedge h_phi2);
        #1 h_rst_b = 1'b1;
        applyStimulus(1, 8'h33, 0, 0, 0); checkOutput("post_reset", 8'h33, 0, 0, 0, 0, 0);

        @(posedge h_phi2);
        @(posedge h_phi2);
        #1;
        nChecks++;
        if (sb.size() != 0) begin
            nErrors++;
            $display("[TB] FAIL drain: scoreboard has %0d pending entries, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
